// File: rtl/ft_test_engine.sv
// Command-driven FIFO traffic engine: decodes 64-bit host frames, streams INC/LFSR
// patterns into the TX FIFO, checks RX traffic against the same pattern and reports status.
module ft_test_engine #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned LED_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rxfifo_empty,
    output logic              rxfifo_rd,
    input  logic              rxfifo_valid,
    input  logic [DATA_W-1:0] rxfifo_data,
    input  logic              txfifo_full,
    output logic              txfifo_wr,
    output logic [DATA_W-1:0] txfifo_data,
    output logic [LED_W-1:0]  led,
    output logic              test_busy,
    output logic [31:0]       err_cnt
);
    localparam int unsigned STAT_WORDS = 1 + 32 / DATA_W;
    localparam int unsigned ST_W       = 3;
    localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     LFSR_SEED = 32'h0000_0001;

    typedef enum logic [2:0] {
        CMD_WAIT, CMD_READ, CMD_PARSE, TX_TEST, RX_TEST, STATUS
    } state_e;

    state_e            state_q;
    logic [63:0]       window_q;
    logic              mode_q;
    logic [31:0]       n_q, cnt_q, iss_q, lfsr_q, err_q;
    logic [TO_W-1:0]   idle_q;
    logic              timeout_q;
    logic [ST_W-1:0]   st_idx_q;
    logic              rd_q, wr_q, busy_q;
    logic [DATA_W-1:0] data_q;
    logic [LED_W-1:0]  led_q;

    logic [63:0]       window_d;
    logic [31:0]       cnt_d, lfsr_d;
    logic [DATA_W-1:0] pat_cur, pat_next;
    logic [15:0]       frame_code;
    logic [31:0]       frame_arg;
    logic              frame_ok, rx_exit;
    logic [7:0]        status_code;

    assign window_d    = {rxfifo_data, window_q[63:DATA_W]};
    assign frame_ok    = (window_q[63:56] == 8'hAA) && (window_q[7:0] == 8'h55);
    assign frame_code  = window_q[55:40];
    assign frame_arg   = window_q[39:8];

    // Pattern word k: INC uses the word index, LFSR uses the k-th register state.
    assign cnt_d    = cnt_q + 32'd1;
    assign lfsr_d   = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    assign pat_cur  = mode_q ? lfsr_q[DATA_W-1:0] : cnt_q[DATA_W-1:0];
    assign pat_next = mode_q ? lfsr_d[DATA_W-1:0] : cnt_d[DATA_W-1:0];

    assign rx_exit     = rxfifo_valid ? (cnt_d == n_q) : (idle_q == TO_LAST);
    assign status_code = timeout_q ? 8'hE0 : ((err_q != 32'd0) ? 8'hEE : 8'h42);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= CMD_WAIT;
            window_q  <= '0;
            mode_q    <= 1'b0;
            n_q       <= '0;
            cnt_q     <= '0;
            iss_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            err_q     <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
            st_idx_q  <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            led_q     <= '0;
        end else begin
            rd_q <= 1'b0;
            case (state_q)
                CMD_WAIT: begin
                    if (!rxfifo_empty) begin
                        rd_q    <= 1'b1;
                        state_q <= CMD_READ;
                    end
                end
                CMD_READ: begin
                    if (rxfifo_valid) begin
                        window_q <= window_d;
                        state_q  <= CMD_PARSE;
                    end
                end
                CMD_PARSE: begin
                    state_q <= CMD_WAIT;
                    if (frame_ok) begin
                        window_q  <= '0;
                        n_q       <= frame_arg;
                        cnt_q     <= '0;
                        iss_q     <= '0;
                        idle_q    <= '0;
                        lfsr_q    <= LFSR_SEED;
                        timeout_q <= 1'b0;
                        st_idx_q  <= '0;
                        case (frame_code)
                            16'hBEEF: begin
                                if (frame_arg != 32'd0) begin
                                    state_q <= TX_TEST;
                                    busy_q  <= 1'b1;
                                    wr_q    <= 1'b1;
                                    data_q  <= mode_q ? DATA_W'(LFSR_SEED) : '0;
                                end
                            end
                            16'hCAFE: begin
                                state_q <= (frame_arg == 32'd0) ? STATUS : RX_TEST;
                                busy_q  <= 1'b1;
                                err_q   <= '0;
                            end
                            16'h1ED0: led_q  <= frame_arg[LED_W-1:0];
                            16'h5E1D: mode_q <= frame_arg[0];
                            default: ;
                        endcase
                    end
                end
                TX_TEST: begin
                    if (wr_q && !txfifo_full) begin
                        cnt_q  <= cnt_d;
                        lfsr_q <= lfsr_d;
                        data_q <= pat_next;
                        if (cnt_d == n_q) begin
                            wr_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= CMD_WAIT;
                        end
                    end
                end
                RX_TEST: begin
                    if (rxfifo_valid) begin
                        idle_q <= '0;
                        cnt_q  <= cnt_d;
                        lfsr_q <= lfsr_d;
                        if ((rxfifo_data != pat_cur) && (err_q != 32'hFFFF_FFFF)) begin
                            err_q <= err_q + 32'd1;
                        end
                    end else if (idle_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                    end else begin
                        idle_q <= idle_q + TO_W'(1);
                    end
                    // Reads are spaced so the registered strobe never outruns the empty flag.
                    if (rx_exit) begin
                        state_q <= STATUS;
                    end else if (!rxfifo_empty && !rd_q && (iss_q < n_q)) begin
                        rd_q  <= 1'b1;
                        iss_q <= iss_q + 32'd1;
                    end
                end
                STATUS: begin
                    // First cycle latches the code once err/timeout have settled.
                    if (!wr_q) begin
                        wr_q   <= 1'b1;
                        data_q <= DATA_W'(status_code);
                    end else if (!txfifo_full) begin
                        if (st_idx_q == ST_W'(STAT_WORDS - 1)) begin
                            wr_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= CMD_WAIT;
                        end else begin
                            st_idx_q <= st_idx_q + ST_W'(1);
                            data_q   <= DATA_W'(err_q >> (DATA_W * 32'(st_idx_q)));
                        end
                    end
                end
                default: state_q <= CMD_WAIT;
            endcase
        end
    end

    assign rxfifo_rd   = rd_q;
    assign txfifo_wr   = wr_q;
    assign txfifo_data = data_q;
    assign led         = led_q;
    assign test_busy   = busy_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_ft_test_engine.sv
// Scoreboard bench for ft_test_engine (DATA_W=8): directed host commands, an RX FIFO
// model feeding the DUT and a TX monitor popping expected words from a queue.
module tb_ft_test_engine;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LED_W  = 8;
    localparam int unsigned TMO    = 16;

    logic              clk          = 1'b0;
    logic              rst_n        = 1'b0;
    logic              rxfifo_empty = 1'b1;
    logic              rxfifo_rd;
    logic              rxfifo_valid = 1'b0;
    logic [DATA_W-1:0] rxfifo_data  = '0;
    logic              txfifo_full  = 1'b0;
    logic              txfifo_wr;
    logic [DATA_W-1:0] txfifo_data;
    logic [LED_W-1:0]  led;
    logic              test_busy;
    logic [31:0]       err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int vcyc     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rxq[$];

    ft_test_engine #(.DATA_W(DATA_W), .LED_W(LED_W), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .rxfifo_empty (rxfifo_empty),
        .rxfifo_rd    (rxfifo_rd),
        .rxfifo_valid (rxfifo_valid),
        .rxfifo_data  (rxfifo_data),
        .txfifo_full  (txfifo_full),
        .txfifo_wr    (txfifo_wr),
        .txfifo_data  (txfifo_data),
        .led          (led),
        .test_busy    (test_busy),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // RX FIFO: data/valid one cycle after an accepted read strobe.
    always @(posedge clk) begin
        logic take;
        take = rxfifo_rd && (rxq.size() > 0);
        #1;
        if (take) begin
            rxfifo_data  = rxq.pop_front();
            rxfifo_valid = 1'b1;
            vcyc         = cyc;
        end else begin
            rxfifo_valid = 1'b0;
        end
        rxfifo_empty = (rxq.size() == 0);
    end

    // TX monitor: every accepted word must match the head of the expected queue.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && txfifo_wr && !txfifo_full) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx_unexpected: got %0h expected no word", txfifo_data);
            end else begin
                e = exp_q.pop_front();
                check("tx_word", 32'(txfifo_data), 32'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] code, input logic [31:0] arg);
        logic [63:0] f;
        f = {8'hAA, code, arg, 8'h55};
        for (int i = 0; i < 8; i++) rxq.push_back(f[8*i +: 8]);
    endtask

    task automatic exp_inc(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(i));
    endtask

    task automatic exp_status(input logic [7:0] code, input logic [31:0] err);
        exp_q.push_back(code);
        for (int i = 0; i < 4; i++) exp_q.push_back(err[8*i +: 8]);
    endtask

    task automatic run_test(input string name);
        for (int i = 0; i < 300 && !test_busy; i++) tick(1);
        check({name, "_busy_rise"}, 32'(test_busy), 32'd1);
        for (int i = 0; i < 3000 && test_busy; i++) tick(1);
        check({name, "_busy_fall"}, 32'(test_busy), 32'd0);
        tick(2);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic settle(input string name);
        for (int i = 0; i < 300 && rxq.size() != 0; i++) tick(1);
        check({name, "_rx_consumed"}, 32'(rxq.size()), 32'd0);
        tick(6);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("rst_wr", 32'(txfifo_wr), 32'd0);
        check("rst_rd", 32'(rxfifo_rd), 32'd0);
        check("rst_data", 32'(txfifo_data), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_busy", 32'(test_busy), 32'd0);
        check("rst_err", err_cnt, 32'd0);
        rst_n = 1'b1;
        tick(2);

        exp_inc(4);
        send_cmd(16'hBEEF, 32'd4);
        run_test("tx4");

        exp_inc(3);
        send_cmd(16'hBEEF, 32'd3);
        for (int i = 0; i < 300 && !txfifo_wr; i++) tick(1);
        check("stall_first_wr", 32'(txfifo_wr), 32'd1);
        tick(1);
        txfifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_data", 32'(txfifo_data), 32'h01);
            check("stall_wr", 32'(txfifo_wr), 32'd1);
        end
        txfifo_full = 1'b0;
        run_test("tx3_stall");

        exp_status(8'hEE, 32'd1);
        send_cmd(16'hCAFE, 32'd4);
        rxq.push_back(8'h00); rxq.push_back(8'h01); rxq.push_back(8'hFF); rxq.push_back(8'h03);
        run_test("rx4_err");
        check("rx4_err_cnt", err_cnt, 32'd1);

        send_cmd(16'hBEEF, 32'd0);
        settle("tx_n0");
        check("tx_n0_busy", 32'(test_busy), 32'd0);
        check("tx_n0_err_kept", err_cnt, 32'd1);

        exp_status(8'h42, 32'd0);
        send_cmd(16'hCAFE, 32'd0);
        run_test("rx_n0");
        check("rx_n0_err_cnt", err_cnt, 32'd0);

        // LFSR states from seed 1: 00000001, 00000003, 00000006
        send_cmd(16'h5E1D, 32'd1);
        exp_q.push_back(8'h01); exp_q.push_back(8'h03); exp_q.push_back(8'h06);
        send_cmd(16'hBEEF, 32'd3);
        run_test("tx_lfsr");
        exp_status(8'h42, 32'd0);
        send_cmd(16'hCAFE, 32'd2);
        rxq.push_back(8'h01); rxq.push_back(8'h03);
        run_test("rx_lfsr");
        send_cmd(16'h5E1D, 32'd0);
        settle("mode_inc");

        exp_status(8'hE0, 32'd0);
        send_cmd(16'hCAFE, 32'd2);
        rxq.push_back(8'h00);
        for (int i = 0; i < 500 && !txfifo_wr; i++) tick(1);
        // 16 idle cycles after the valid, plus STATUS entry and code latch
        check("timeout_latency", 32'(cyc - vcyc), 32'(TMO + 2));
        run_test("rx_timeout");

        rxq.push_back(8'h12); rxq.push_back(8'h34); rxq.push_back(8'hAA);
        send_cmd(16'h1ED0, 32'h0000_00A5);
        settle("led");
        check("led_value", 32'(led), 32'hA5);
        send_cmd(16'h1234, 32'd5);
        settle("bad_code");
        check("bad_code_led", 32'(led), 32'hA5);
        check("bad_code_busy", 32'(test_busy), 32'd0);

        send_cmd(16'h5E1D, 32'd1);
        txfifo_full = 1'b1;
        send_cmd(16'hBEEF, 32'd50);
        for (int i = 0; i < 300 && !test_busy; i++) tick(1);
        check("pre_reset_wr", 32'(txfifo_wr), 32'd1);
        check("pre_reset_data", 32'(txfifo_data), 32'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr", 32'(txfifo_wr), 32'd0);
        check("mid_rst_busy", 32'(test_busy), 32'd0);
        check("mid_rst_data", 32'(txfifo_data), 32'd0);
        check("mid_rst_led", 32'(led), 32'd0);
        tick(2);
        txfifo_full = 1'b0;
        rst_n = 1'b1;
        tick(2);
        exp_inc(2);
        send_cmd(16'hBEEF, 32'd2);
        run_test("tx_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
